// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and constants for the hazard controller
package pipeline_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } hz_state_t;

    localparam int REG_AW_DEF = 5;
    localparam int X0         = 0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, EX redirect squash and hazard performance counters
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch,
    input  logic              ex_jump,
    input  logic              ex_zero,
    input  logic              mem_stall,
    input  logic              cnt_clear,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    hz_state_t state;
    hz_state_t state_next;
    logic      taken;
    logic      load_use;
    logic      stall_inc;
    logic      flush_inc;

    assign taken    = ex_jump | (ex_branch & ex_zero);
    assign load_use = ex_mem_read && (ex_rd != REG_AW'(X0)) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        flush_inc  = 1'b0;
        if (!reset_n) begin
            state_next = RUN;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (taken) begin
            // A taken seen in SHADOW redirects like RUN and keeps the shadow open.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = SHADOW;
            flush_inc  = 1'b1;
        end else if (state == SHADOW) begin
            // The fetch this cycle used the stale PC, and ID holds a bubble.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = RUN;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign stall_inc = reset_n & ~pc_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clear),
        .inc     (stall_inc),
        .count   (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clear),
        .inc     (flush_inc),
        .count   (flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2, ex_mem_read;
    logic              ex_branch, ex_jump, ex_zero, mem_stall, cnt_clear;
    logic              pc_write, ifid_write, ifid_flush, idex_flush;
    logic [CNT_W-1:0]  stall_cycles, flush_events;

    int vectors    = 0;
    int miscompares = 0;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_zero      (ex_zero),
        .mem_stall    (mem_stall),
        .cnt_clear    (cnt_clear),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ctrl order: {pc_write, ifid_write, ifid_flush, idex_flush}
    task automatic chk_ctrl(input string tag, input logic [3:0] expected);
        chk(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, expected});
    endtask

    task automatic chk_cnt(input string tag, input int stalls, input int flushes);
        chk({tag, "_stall"}, 32'(stall_cycles), 32'(stalls));
        chk({tag, "_flush"}, 32'(flush_events), 32'(flushes));
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
        ex_branch = 0; ex_jump = 0; ex_zero = 0;
        mem_stall = 0; cnt_clear = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #3;
        chk_ctrl("reset_ctrl", 4'b0011);
        chk_cnt("reset", 0, 0);
        tick();
        chk_ctrl("reset_hold_ctrl", 4'b0011);
        chk_cnt("reset_hold", 0, 0);
        reset_n = 1'b1;
        settle();
        chk_ctrl("run_idle", 4'b1100);
        tick();

        // load-use on rs2: exactly one bubble cycle
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        settle();
        chk_ctrl("lu_rs2", 4'b0001);
        tick();
        idle();
        settle();
        chk_ctrl("lu_after", 4'b1100);
        chk_cnt("lu", 1, 0);
        tick();

        // destination x0 never stalls
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        settle();
        chk_ctrl("lu_x0", 4'b1100);
        tick();
        chk_cnt("lu_x0", 1, 0);

        // match on rs1 that is not read: no stall; then read: stall
        idle();
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
        settle();
        chk_ctrl("lu_rs1_unused", 4'b1100);
        tick();
        id_use_rs1 = 1;
        settle();
        chk_ctrl("lu_rs1", 4'b0001);
        tick();
        chk_cnt("lu_rs1", 2, 0);

        // non-load producer does not stall
        ex_mem_read = 0;
        settle();
        chk_ctrl("no_load", 4'b1100);
        tick();

        // clear
        idle();
        cnt_clear = 1;
        tick();
        chk_cnt("clear", 0, 0);
        cnt_clear = 0;

        // branch not taken
        ex_branch = 1; ex_zero = 0;
        settle();
        chk_ctrl("br_nt", 4'b1100);
        tick();

        // branch taken: redirect then shadow
        ex_zero = 1;
        settle();
        chk_ctrl("br_t", 4'b1111);
        tick();
        idle();
        settle();
        chk_ctrl("br_shadow", 4'b1111);
        chk_cnt("br_t", 0, 1);
        tick();
        settle();
        chk_ctrl("br_run", 4'b1100);
        tick();
        chk_cnt("br_end", 0, 1);

        // taken held behind three mem_stall cycles
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        ex_branch = 1; ex_zero = 1; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctrl("ms_frozen", 4'b0000);
            tick();
        end
        mem_stall = 0;
        settle();
        chk_ctrl("ms_redirect", 4'b1111);
        chk_cnt("ms_pre", 3, 0);
        tick();
        idle();
        settle();
        chk_ctrl("ms_shadow", 4'b1111);
        tick();
        settle();
        chk_ctrl("ms_run", 4'b1100);
        chk_cnt("ms", 3, 1);
        tick();

        // jump with concurrent load-use: flush wins, no stall
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        ex_jump = 1; ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        settle();
        chk_ctrl("jmp_lu", 4'b1111);
        tick();
        ex_jump = 0;
        settle();
        chk_ctrl("shadow_ignores_lu", 4'b1111);
        chk_cnt("jmp_lu", 0, 1);
        tick();
        idle();

        // taken asserted in SHADOW redirects again and stays in SHADOW
        ex_jump = 1;
        tick();
        settle();
        chk_ctrl("shadow_taken", 4'b1111);
        tick();
        ex_jump = 0;
        settle();
        chk_ctrl("shadow_again", 4'b1111);
        chk_cnt("shadow_taken", 0, 3);
        tick();
        settle();
        chk_ctrl("shadow_exit", 4'b1100);
        tick();

        // reset pulsed in SHADOW
        ex_jump = 1;
        tick();
        ex_jump = 0;
        settle();
        chk_ctrl("pre_rst_shadow", 4'b1111);
        reset_n = 1'b0;
        #1;
        chk_ctrl("rst_in_shadow", 4'b0011);
        chk_cnt("rst_in_shadow", 0, 0);
        tick();
        reset_n = 1'b1;
        settle();
        chk_ctrl("rst_release_run", 4'b1100);
        tick();

        // saturation, then clear with concurrent stall
        mem_stall = 1;
        for (int i = 0; i < 18; i++) tick();
        chk_cnt("sat", 15, 0);
        cnt_clear = 1;
        tick();
        chk_cnt("clr_vs_stall", 0, 0);
        cnt_clear = 0;
        tick();
        chk_cnt("post_clr", 1, 0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
